// File: rtl/rs_ino_entries_pkg.sv
// Shared width/count defaults for the in-order reservation station entries.
// Every rs_ino_* module takes its parameter defaults from here.
package rs_ino_entries_pkg;
  localparam int ENTSEL_W      = 2;
  localparam int ENTNUM_N      = 1 << ENTSEL_W;
  localparam int DATA_LEN_W    = 32;
  localparam int RRF_SEL_W     = 6;
  localparam int SPECTAG_LEN_W = 5;
endpackage

// File: rtl/rs_ino_entries_entry.sv
// rs_ino_entry: one reservation-station slot (busy, two sources with wakeup, imm, tags, kill).
// State updates on the clk edge; no backpressure. RS_WRITE_BYPASS_EN enables wakeup of write data.
module rs_ino_entry
  import rs_ino_entries_pkg::*;
#(
  parameter int DATA_LEN    = DATA_LEN_W,
  parameter int RRF_SEL     = RRF_SEL_W,
  parameter int SPECTAG_LEN = SPECTAG_LEN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [DATA_LEN:0]      wsrc1,
  input  logic [DATA_LEN:0]      wsrc2,
  input  logic [DATA_LEN-1:0]    wimm,
  input  logic [RRF_SEL-1:0]     wrrftag,
  input  logic [SPECTAG_LEN-1:0] wspectag,
  input  logic [DATA_LEN-1:0]    rslt1,
  input  logic [RRF_SEL-1:0]     rslt1_tag,
  input  logic                   rslt1_vld,
  input  logic [DATA_LEN-1:0]    rslt2,
  input  logic [RRF_SEL-1:0]     rslt2_tag,
  input  logic                   rslt2_vld,
  input  logic                   clr,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  output logic                   busy,
  output logic                   ready,
  output logic                   busy_pr,
  output logic [DATA_LEN-1:0]    src1_dat,
  output logic [DATA_LEN-1:0]    src2_dat,
  output logic [DATA_LEN-1:0]    imm,
  output logic [RRF_SEL-1:0]     rrftag,
  output logic [SPECTAG_LEN-1:0] spectag
);

  // Sources are {data, valid}; while invalid the low data bits carry the producer tag.
  logic [DATA_LEN:0]      src1, src2;
  logic [DATA_LEN:0]      wsrc1_in, wsrc2_in;
  logic [SPECTAG_LEN-1:0] spec_base, spec_nxt;
  logic                   killed, wkilled;

  function automatic logic [DATA_LEN:0] wake(input logic [DATA_LEN:0] s);
    logic [DATA_LEN:0] r;
    r = s;
    if (!s[0]) begin
      if (rslt1_vld && (s[RRF_SEL:1] == rslt1_tag))
        r = {rslt1, 1'b1};
      else if (rslt2_vld && (s[RRF_SEL:1] == rslt2_tag))
        r = {rslt2, 1'b1};
    end
    return r;
  endfunction

`ifdef RS_WRITE_BYPASS_EN
  assign wsrc1_in = wake(wsrc1);
  assign wsrc2_in = wake(wsrc2);
`else
  assign wsrc1_in = wsrc1;
  assign wsrc2_in = wsrc2;
`endif

  assign killed  = prmiss && (|(spectag & prtag));
  assign wkilled = prmiss && (|(wspectag & prtag));
  assign busy_pr = busy && !clr && !killed;
  assign ready   = busy && src1[0] && src2[0];

  // A miss leaves the surviving tags alone; only a lone success retires the branch bit.
  assign spec_base = we ? wspectag : spectag;
  assign spec_nxt  = (prsuccess && !prmiss) ? (spec_base & ~prtag) : spec_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      busy <= 1'b0;
    else if (we)
      busy <= !wkilled;
    else
      busy <= busy_pr;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      src1   <= wsrc1_in;
      src2   <= wsrc2_in;
      imm    <= wimm;
      rrftag <= wrrftag;
    end else if (busy) begin
      src1 <= wake(src1);
      src2 <= wake(src2);
    end
    spectag <= spec_nxt;
  end

  assign src1_dat = src1[DATA_LEN:1];
  assign src2_dat = src2[DATA_LEN:1];

endmodule

// File: rtl/rs_ino_entries.sv
// rs_ino_entries: ENTNUM-entry in-order reservation station; 2 writes/cycle, issue read is combinational.
// Writes/issue/kill take effect on the next clk edge; no backpressure. Optional RS_WRITE_BYPASS_EN.
module rs_ino_entries
  import rs_ino_entries_pkg::*;
#(
  parameter int ENTSEL      = ENTSEL_W,
  parameter int ENTNUM      = ENTNUM_N,
  parameter int DATA_LEN    = DATA_LEN_W,
  parameter int RRF_SEL     = RRF_SEL_W,
  parameter int SPECTAG_LEN = SPECTAG_LEN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we1,
  input  logic                   we2,
  input  logic [ENTSEL-1:0]      waddr1,
  input  logic [ENTSEL-1:0]      waddr2,
  input  logic [DATA_LEN:0]      wsrc1_1,
  input  logic [DATA_LEN:0]      wsrc2_1,
  input  logic [DATA_LEN-1:0]    wimm_1,
  input  logic [RRF_SEL-1:0]     wrrftag_1,
  input  logic [SPECTAG_LEN-1:0] wspectag_1,
  input  logic [DATA_LEN:0]      wsrc1_2,
  input  logic [DATA_LEN:0]      wsrc2_2,
  input  logic [DATA_LEN-1:0]    wimm_2,
  input  logic [RRF_SEL-1:0]     wrrftag_2,
  input  logic [SPECTAG_LEN-1:0] wspectag_2,
  input  logic [DATA_LEN-1:0]    rslt1,
  input  logic [DATA_LEN-1:0]    rslt2,
  input  logic [RRF_SEL-1:0]     rslt1_tag,
  input  logic [RRF_SEL-1:0]     rslt2_tag,
  input  logic                   rslt1_vld,
  input  logic                   rslt2_vld,
  input  logic                   issue,
  input  logic [ENTSEL-1:0]      issueptr,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  output logic [ENTNUM-1:0]      busyvec,
  output logic [ENTNUM-1:0]      prbusyvec_next,
  output logic [ENTNUM-1:0]      readyvec,
  output logic [DATA_LEN-1:0]    is_src1,
  output logic [DATA_LEN-1:0]    is_src2,
  output logic [DATA_LEN-1:0]    is_imm,
  output logic [RRF_SEL-1:0]     is_rrftag,
  output logic [SPECTAG_LEN-1:0] is_spectag
);

  logic [DATA_LEN-1:0]    e_src1    [ENTNUM];
  logic [DATA_LEN-1:0]    e_src2    [ENTNUM];
  logic [DATA_LEN-1:0]    e_imm     [ENTNUM];
  logic [RRF_SEL-1:0]     e_rrftag  [ENTNUM];
  logic [SPECTAG_LEN-1:0] e_spectag [ENTNUM];

  for (genvar i = 0; i < ENTNUM; i++) begin : g_ent
    logic sel0, sel1;

    // Slot 1 is only meaningful alongside slot 0; the two indices never collide.
    assign sel0 = we1 && (waddr1 == ENTSEL'(i));
    assign sel1 = we1 && we2 && (waddr2 == ENTSEL'(i));

    rs_ino_entry #(
      .DATA_LEN   (DATA_LEN),
      .RRF_SEL    (RRF_SEL),
      .SPECTAG_LEN(SPECTAG_LEN)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .we       (sel0 || sel1),
      .wsrc1    (sel1 ? wsrc1_2    : wsrc1_1),
      .wsrc2    (sel1 ? wsrc2_2    : wsrc2_1),
      .wimm     (sel1 ? wimm_2     : wimm_1),
      .wrrftag  (sel1 ? wrrftag_2  : wrrftag_1),
      .wspectag (sel1 ? wspectag_2 : wspectag_1),
      .rslt1    (rslt1),
      .rslt1_tag(rslt1_tag),
      .rslt1_vld(rslt1_vld),
      .rslt2    (rslt2),
      .rslt2_tag(rslt2_tag),
      .rslt2_vld(rslt2_vld),
      .clr      (issue && (issueptr == ENTSEL'(i))),
      .prmiss   (prmiss),
      .prsuccess(prsuccess),
      .prtag    (prtag),
      .busy     (busyvec[i]),
      .ready    (readyvec[i]),
      .busy_pr  (prbusyvec_next[i]),
      .src1_dat (e_src1[i]),
      .src2_dat (e_src2[i]),
      .imm      (e_imm[i]),
      .rrftag   (e_rrftag[i]),
      .spectag  (e_spectag[i])
    );
  end

  assign is_src1    = e_src1[issueptr];
  assign is_src2    = e_src2[issueptr];
  assign is_imm     = e_imm[issueptr];
  assign is_rrftag  = e_rrftag[issueptr];
  assign is_spectag = e_spectag[issueptr];

endmodule

// File: tb/tb_rs_ino_entries.sv
// Bench for rs_ino_entries: directed literal cases plus randomized traffic against a
// per-entry behavioural model of the reservation station.
module tb_rs_ino_entries;

  logic        clk = 1'b0;
  logic        reset;
  logic        we1, we2;
  logic [1:0]  waddr1, waddr2;
  logic [32:0] wsrc1_1, wsrc2_1, wsrc1_2, wsrc2_2;
  logic [31:0] wimm_1, wimm_2;
  logic [5:0]  wrrftag_1, wrrftag_2;
  logic [4:0]  wspectag_1, wspectag_2;
  logic [31:0] rslt1, rslt2;
  logic [5:0]  rslt1_tag, rslt2_tag;
  logic        rslt1_vld, rslt2_vld;
  logic        issue;
  logic [1:0]  issueptr;
  logic        prmiss, prsuccess;
  logic [4:0]  prtag;
  logic [3:0]  busyvec, prbusyvec_next, readyvec;
  logic [31:0] is_src1, is_src2, is_imm;
  logic [5:0]  is_rrftag;
  logic [4:0]  is_spectag;

  always #5 clk = ~clk;

  rs_ino_entries dut (
    .clk(clk), .reset(reset),
    .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
    .wsrc1_1(wsrc1_1), .wsrc2_1(wsrc2_1), .wimm_1(wimm_1),
    .wrrftag_1(wrrftag_1), .wspectag_1(wspectag_1),
    .wsrc1_2(wsrc1_2), .wsrc2_2(wsrc2_2), .wimm_2(wimm_2),
    .wrrftag_2(wrrftag_2), .wspectag_2(wspectag_2),
    .rslt1(rslt1), .rslt2(rslt2), .rslt1_tag(rslt1_tag), .rslt2_tag(rslt2_tag),
    .rslt1_vld(rslt1_vld), .rslt2_vld(rslt2_vld),
    .issue(issue), .issueptr(issueptr),
    .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag),
    .busyvec(busyvec), .prbusyvec_next(prbusyvec_next), .readyvec(readyvec),
    .is_src1(is_src1), .is_src2(is_src2), .is_imm(is_imm),
    .is_rrftag(is_rrftag), .is_spectag(is_spectag)
  );

`ifdef RS_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Model: one record per entry, kept as plain arrays.
  bit          m_busy [4];
  bit          m_wr   [4];
  bit          m_v1   [4];
  bit          m_v2   [4];
  logic [31:0] m_d1   [4];
  logic [31:0] m_d2   [4];
  logic [31:0] m_imm  [4];
  logic [5:0]  m_rrf  [4];
  logic [4:0]  m_spec [4];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [32:0] wk(input bit v, input logic [31:0] d);
    if (!v && rslt1_vld && d[5:0] == rslt1_tag) return {rslt1, 1'b1};
    if (!v && rslt2_vld && d[5:0] == rslt2_tag) return {rslt2, 1'b1};
    return {d, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 0;
      m_wr[i]   = 0;
    end
  endtask

  task automatic model_write(input int idx, input logic [32:0] s1, input logic [32:0] s2,
                             input logic [31:0] im, input logic [5:0] rt, input logic [4:0] sp);
    logic [32:0] a, b;
    a = s1;
    b = s2;
    if (BYPASS) begin
      a = wk(s1[0], s1[32:1]);
      b = wk(s2[0], s2[32:1]);
    end
    m_v1[idx] = a[0];  m_d1[idx] = a[32:1];
    m_v2[idx] = b[0];  m_d2[idx] = b[32:1];
    m_imm[idx] = im;   m_rrf[idx] = rt;   m_spec[idx] = sp;
    m_busy[idx] = !(prmiss && ((sp & prtag) != 0));
    m_wr[idx] = 1;
  endtask

  function automatic logic [3:0] exp_prbusy();
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = m_busy[i] && !(issue && issueptr == 2'(i))
             && !(prmiss && ((m_spec[i] & prtag) != 0));
    return r;
  endfunction

  task automatic model_step();
    logic [3:0]  nb;
    logic [32:0] t;
    nb = exp_prbusy();
    for (int i = 0; i < 4; i++) begin
      if (m_busy[i]) begin
        t = wk(m_v1[i], m_d1[i]);  m_v1[i] = t[0];  m_d1[i] = t[32:1];
        t = wk(m_v2[i], m_d2[i]);  m_v2[i] = t[0];  m_d2[i] = t[32:1];
      end
      m_busy[i] = nb[i];
    end
    if (we1) model_write(int'(waddr1), wsrc1_1, wsrc2_1, wimm_1, wrrftag_1, wspectag_1);
    if (we1 && we2) model_write(int'(waddr2), wsrc1_2, wsrc2_2, wimm_2, wrrftag_2, wspectag_2);
    if (prsuccess && !prmiss)
      for (int i = 0; i < 4; i++) m_spec[i] = m_spec[i] & ~prtag;
  endtask

  task automatic compare_model();
    logic [3:0] eb, er;
    int p;
    for (int i = 0; i < 4; i++) begin
      eb[i] = m_busy[i];
      er[i] = m_busy[i] && m_v1[i] && m_v2[i];
    end
    chk("busyvec", 32'(busyvec), 32'(eb));
    chk("readyvec", 32'(readyvec), 32'(er));
    chk("prbusyvec_next", 32'(prbusyvec_next), 32'(exp_prbusy()));
    p = int'(issueptr);
    if (m_wr[p]) begin
      chk("is_src1", is_src1, m_d1[p]);
      chk("is_src2", is_src2, m_d2[p]);
      chk("is_imm", is_imm, m_imm[p]);
      chk("is_rrftag", 32'(is_rrftag), 32'(m_rrf[p]));
      chk("is_spectag", 32'(is_spectag), 32'(m_spec[p]));
    end
  endtask

  task automatic idle();
    we1 = 0; we2 = 0; waddr1 = 0; waddr2 = 1;
    wsrc1_1 = 0; wsrc2_1 = 0; wimm_1 = 0; wrrftag_1 = 0; wspectag_1 = 0;
    wsrc1_2 = 0; wsrc2_2 = 0; wimm_2 = 0; wrrftag_2 = 0; wspectag_2 = 0;
    rslt1 = 0; rslt2 = 0; rslt1_tag = 0; rslt2_tag = 0; rslt1_vld = 0; rslt2_vld = 0;
    issue = 0; issueptr = 0; prmiss = 0; prsuccess = 0; prtag = 0;
  endtask

  task automatic slot0(input logic [1:0] a, input logic [32:0] s1, input logic [32:0] s2,
                       input logic [5:0] rt, input logic [4:0] sp);
    we1 = 1; waddr1 = a; waddr2 = a + 2'd1;
    wsrc1_1 = s1; wsrc2_1 = s2; wimm_1 = $urandom; wrrftag_1 = rt; wspectag_1 = sp;
  endtask

  task automatic slot1(input logic [32:0] s1, input logic [32:0] s2,
                       input logic [5:0] rt, input logic [4:0] sp);
    we2 = 1;
    wsrc1_2 = s1; wsrc2_2 = s2; wimm_2 = $urandom; wrrftag_2 = rt; wspectag_2 = sp;
  endtask

  // Inputs are set after a falling edge; outputs checked 1ns later, model advances on the rising edge.
  task automatic tick();
    #1 compare_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [32:0] rnd_src();
    if ($urandom_range(0, 1) == 1) return {32'($urandom), 1'b1};
    return {32'($urandom_range(0, 7)), 1'b0};
  endfunction

  task automatic mid_reset();
    #2 reset = 0;
    model_reset();
    #1;
    chk("rst_busyvec", 32'(busyvec), 32'h0);
    chk("rst_readyvec", 32'(readyvec), 32'h0);
    chk("rst_prbusyvec", 32'(prbusyvec_next), 32'h0);
    @(negedge clk);
    reset = 1;
  endtask

  localparam logic [32:0] V0 = {32'h0000_0001, 1'b1};
  localparam logic [32:0] V1 = {32'h0000_0002, 1'b1};

  initial begin
    reset = 0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("init_busyvec", 32'(busyvec), 32'h0);
    chk("init_readyvec", 32'(readyvec), 32'h0);
    chk("init_prbusyvec", 32'(prbusyvec_next), 32'h0);
    reset = 1;
    @(negedge clk);

    // Wrapped pair write 3/0, all sources valid.
    slot0(2'd3, V0, V1, 6'h01, 5'd0);
    slot1(V1, V0, 6'h02, 5'd0);
    tick(); idle(); #1;
    chk("wrap_busyvec", 32'(busyvec), 32'h9);
    chk("wrap_readyvec", 32'(readyvec), 32'h9);

    // Wakeup of entry 1 src2 from result bus 2.
    slot0(2'd1, V0, {32'h12, 1'b0}, 6'h03, 5'd0);
    tick(); idle(); #1;
    chk("wait_ready1", 32'(readyvec[1]), 32'h0);
    rslt2_tag = 6'h12; rslt2 = 32'hDEADBEEF; rslt2_vld = 1; issueptr = 2'd1;
    tick(); idle(); issueptr = 2'd1; #1;
    chk("wake_ready1", 32'(readyvec[1]), 32'h1);
    chk("wake_is_src2", is_src2, 32'hDEADBEEF);

    // Mispredict kill: spectags 1,2,3 and entry 3 issued away.
    slot0(2'd0, V0, V1, 6'h04, 5'b00001);
    slot1(V0, V1, 6'h05, 5'b00010);
    issue = 1; issueptr = 2'd3;
    tick(); idle();
    slot0(2'd2, V0, V1, 6'h06, 5'b00011);
    tick(); idle();
    prmiss = 1; prtag = 5'b00010; #1;
    chk("kill_prbusyvec", 32'(prbusyvec_next), 32'h1);
    tick(); idle(); #1;
    chk("kill_busyvec", 32'(busyvec), 32'h1);

    // Issue and rewrite of the same index.
    slot0(2'd2, V0, V1, 6'h11, 5'd0);
    tick(); idle();
    slot0(2'd2, V0, V1, 6'h2A, 5'd0);
    issue = 1; issueptr = 2'd2;
    tick(); idle(); issueptr = 2'd2; #1;
    chk("reissue_busy2", 32'(busyvec[2]), 32'h1);
    chk("reissue_rrftag", 32'(is_rrftag), 32'h2A);

    // Write racing a matching result broadcast.
    slot0(2'd3, {32'h5, 1'b0}, V1, 6'h07, 5'd0);
    rslt1_tag = 6'h05; rslt1 = 32'hCAFE0005; rslt1_vld = 1;
    tick(); idle(); #1;
    chk("race_ready3", 32'(readyvec[3]), 32'(BYPASS));
    rslt1_tag = 6'h05; rslt1 = 32'hCAFE0006; rslt1_vld = 1;
    tick(); idle(); issueptr = 2'd3; #1;
    chk("late_ready3", 32'(readyvec[3]), 32'h1);
    chk("late_src1", is_src1, BYPASS ? 32'hCAFE0005 : 32'hCAFE0006);

    // Mid-cycle reset with entries 0,2,3 busy.
    chk("pre_reset_busyvec", 32'(busyvec), 32'hD);
    mid_reset();

    for (int c = 0; c < 1500; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1) begin
        slot0(2'($urandom), rnd_src(), rnd_src(), 6'($urandom), 5'($urandom) & 5'($urandom));
        if ($urandom_range(0, 1) == 1)
          slot1(rnd_src(), rnd_src(), 6'($urandom), 5'($urandom) & 5'($urandom));
      end else if ($urandom_range(0, 7) == 0) begin
        slot1(rnd_src(), rnd_src(), 6'($urandom), 5'($urandom));
      end
      rslt1_vld = 1'($urandom); rslt1_tag = 6'($urandom_range(0, 7)); rslt1 = $urandom;
      rslt2_vld = 1'($urandom); rslt2_tag = 6'($urandom_range(0, 7)); rslt2 = $urandom;
      issue = ($urandom_range(0, 9) < 3);
      issueptr = 2'($urandom);
      prmiss = ($urandom_range(0, 29) == 0);
      prsuccess = ($urandom_range(0, 9) == 0);
      prtag = 5'($urandom);
      tick();
      if (c == 700) begin
        idle();
        mid_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
